// File: rtl/nx_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// nx_alu_seq_pkg
// Shared types and helpers for the chunk-serial add/subtract controller.
//   state_t     : controller FSM states (IDLE, RUN, DONE)
//   nch()       : number of chunks for a given WIDTH/CHUNK
//   cnt_w()     : width of a counter that indexes nch() chunks (at least 1)
//   rr_grant()  : round-robin one-hot grant over the first nreq bits of a
//                 MAX_NREQ-wide valid vector, search starting at ptr
// -----------------------------------------------------------------------------
package nx_alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Upper bound on requesters handled by rr_grant(); also the width of its
  // valid/grant vectors. MAX_IDW indexes any bit of such a vector.
  localparam int MAX_NREQ = 32;
  localparam int MAX_IDW  = 5;

  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width for the default 32-bit / 4-bit configuration.
  localparam int CNT_W_DEFAULT = cnt_w(nch(32, 4));

  // Returns a one-hot vector selecting the first valid requester found when
  // scanning ptr, ptr+1, ... wrapping modulo nreq. All zero if none valid.
  function automatic logic [MAX_NREQ-1:0] rr_grant(
    input logic [MAX_NREQ-1:0] valid,
    input int unsigned         nreq,
    input int unsigned         ptr
  );
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int unsigned         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if ((i < nreq) && !found) begin
        // ptr < nreq, so a single conditional subtract implements the wrap.
        idx = ptr + i;
        if (idx >= nreq) idx = idx - nreq;
        if (valid[MAX_IDW'(idx)]) begin
          grant[MAX_IDW'(idx)] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/nx_alu_chunk.sv
// -----------------------------------------------------------------------------
// nx_alu_chunk
// Combinational CHUNK-bit adder slice: {co, s} = a + b + ci. Kept as a single
// plain addition so synthesis maps it onto CHUNK/4 NX_CY carry cells.
//   a, b   in  CHUNK  addends
//   ci     in  1      carry in
//   s      out CHUNK  sum
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (for signed overflow detection)
// -----------------------------------------------------------------------------
module nx_alu_chunk
  import nx_alu_seq_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);

  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/nx_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// nx_alu_seq_ctrl
// Shares one CHUNK-bit adder slice between NREQ requesters and performs a
// WIDTH-bit add or subtract serially, CHUNK bits per cycle, LSB chunk first.
// Optional feature macro: NX_ALU_SEQ_OVF_EN adds the rsp_ovf output.
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   req_valid  in   NREQ        per-requester request
//   req_ready  out  NREQ        one-hot accept (IDLE only)
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   req_sub    in   NREQ        1 = A-B, 0 = A+B
//   rsp_valid  out  1           result valid (held until rsp_ready)
//   rsp_ready  in   1           result consumed
//   rsp_y      out  WIDTH       result
//   rsp_co     out  1           carry out of MSB (subtract: 1 = no borrow)
//   rsp_id     out  IDW         owner of the result
//   rsp_ovf    out  1           signed overflow (NX_ALU_SEQ_OVF_EN only)
// -----------------------------------------------------------------------------
module nx_alu_seq_ctrl
  import nx_alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 4,
  parameter  int NREQ  = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_co,
  output logic [IDW-1:0]        rsp_id
`ifdef NX_ALU_SEQ_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  localparam int NCH   = nch(WIDTH, CHUNK);
  localparam int CNT_W = cnt_w(NCH);

  // Elaboration-time parameter checks.
  if (CHUNK < 4 || (CHUNK % 4) != 0) begin : g_chk_chunk
    $error("nx_alu_seq_ctrl: CHUNK (%0d) must be a positive multiple of 4", CHUNK);
  end
  if ((WIDTH % CHUNK) != 0) begin : g_chk_width
    $error("nx_alu_seq_ctrl: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end
  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_chk_nreq
    $error("nx_alu_seq_ctrl: NREQ (%0d) must be in 2..%0d", NREQ, MAX_NREQ);
  end

  state_t            state;
  logic [IDW-1:0]    rr;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;   // already inverted for subtract

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [MAX_NREQ-1:0] valid_ext;
  logic [MAX_NREQ-1:0] grant_ext;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      gidx;
  logic                unused_grant_hi;

  // NOTE: every variable written in always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = req_valid;
    grant_ext              = rr_grant(valid_ext, NREQ, 32'(rr));
    grant                  = grant_ext[NREQ-1:0];
    gidx                   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = IDW'(i);
    end
  end

  // Bits above NREQ are always zero; fold them away explicitly.
  assign unused_grant_hi = ^grant_ext;

  assign req_ready = (state == IDLE) ? grant : '0;

  // ---------------------------------------------------------------------------
  // Shared adder slice
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] s_k;
  logic             c_out;
  logic             c_msb;
  logic             last_chunk;

  assign a_k        = a_q[cnt*CHUNK +: CHUNK];
  assign b_k        = b_q[cnt*CHUNK +: CHUNK];
  assign last_chunk = (cnt == CNT_W'(NCH-1));

  nx_alu_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_k),
    .b     (b_k),
    .ci    (carry),
    .s     (s_k),
    .co    (c_out),
    .c_msb (c_msb)
  );

`ifndef NX_ALU_SEQ_OVF_EN
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

  // ---------------------------------------------------------------------------
  // Controller FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a_q/b_q are pure datapath and are always loaded before use, so
      // they are deliberately left out of reset.
      state     <= IDLE;
      rr        <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_co    <= 1'b0;
      rsp_id    <= '0;
`ifdef NX_ALU_SEQ_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            a_q    <= req_a[gidx*WIDTH +: WIDTH];
            b_q    <= req_b[gidx*WIDTH +: WIDTH] ^ {WIDTH{req_sub[gidx]}};
            // Subtract = A + ~B + 1: the +1 enters as the first carry-in.
            carry  <= req_sub[gidx];
            rsp_id <= gidx;
            rr     <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            cnt    <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          rsp_y[cnt*CHUNK +: CHUNK] <= s_k;
          carry                     <= c_out;
          if (last_chunk) begin
            rsp_co    <= c_out;
`ifdef NX_ALU_SEQ_OVF_EN
            rsp_ovf   <= c_msb ^ c_out;
`endif
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // Return to IDLE only; arbitration resumes the following cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nx_alu_seq_ctrl
// Self-checking bench for nx_alu_seq_ctrl (WIDTH=32, CHUNK=4, NREQ=2).
// Directed vector table, round-robin sequence, DONE back-pressure, mid-RUN
// reset and randomized operations checked against an arithmetic model.
// Define NX_ALU_SEQ_OVF_EN to also exercise rsp_ovf.
// -----------------------------------------------------------------------------
module tb_nx_alu_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;
  localparam int NCH   = WIDTH / CHUNK;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic                  rsp_co;
  logic [IDW-1:0]        rsp_id;
`ifdef NX_ALU_SEQ_OVF_EN
  logic                  rsp_ovf;
`endif

  nx_alu_seq_ctrl #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_co    (rsp_co),
    .rsp_id    (rsp_id)
`ifdef NX_ALU_SEQ_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_bad     = 0;
  int model_ptr = 0;   // reference round-robin pointer

  // ---------------------------------------------------------------------------
  // Checking helpers and reference model
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // First valid requester scanning from ptr with wrap.
  function automatic int exp_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (ptr + i) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Returns {ovf, co, y} from plain two's-complement arithmetic.
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    logic [32:0] sum;
    logic        ovf;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + 33'(sub);
    ovf = (a[31] == bb[31]) && (sum[31] != a[31]);
    return {ovf, sum[32], sum[31:0]};
  endfunction

  // One complete operation: request, grant check, latency, result,
  // optional DONE stall with stability checks, then handshake.
  task automatic do_op(input string name, input logic [1:0] vmask,
                       input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                       input int stall, input logic [31:0] exp_y, input logic exp_co,
                       input int exp_id, input logic exp_ovf);
    int          g;
    int          lat;
    bit          ready_quiet;
    logic [1:0]  oh;
    logic [31:0] y_snap;
    logic        co_snap;
    logic [IDW-1:0] id_snap;
    g      = exp_grant(vmask, model_ptr);
    oh     = '0;
    oh[g]  = 1'b1;
    @(negedge clk);
    req_valid = vmask;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_sub   = {s1, s0};
    rsp_ready = 1'b0;
    #1;
    check({name, ".grant"}, req_ready, oh);
    @(posedge clk);
    #1;
    model_ptr = (g + 1) % NREQ;
    // Inputs after the accept cycle must be ignored.
    req_valid   = 2'b11;
    req_a       = {$urandom, $urandom};
    req_b       = {$urandom, $urandom};
    req_sub     = 2'($urandom);
    ready_quiet = 1'b1;
    lat         = 0;
    while (lat < 4 * NCH + 8) begin
      if (rsp_valid) break;
      if (req_ready !== '0) ready_quiet = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      note_fail({name, ".rsp_valid"});
      req_valid = '0;
      return;
    end
    // Valid in cycle T+NCH+1, i.e. NCH edges after the accepting edge.
    check({name, ".latency"}, lat, NCH);
    check({name, ".ready_in_run"}, ready_quiet, 1'b1);
    check({name, ".y"}, rsp_y, exp_y);
    check({name, ".co"}, rsp_co, exp_co);
    check({name, ".id"}, rsp_id, exp_id);
`ifdef NX_ALU_SEQ_OVF_EN
    check({name, ".ovf"}, rsp_ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("note: %s has unknown ovf expectation", name);
`endif
    y_snap  = rsp_y;
    co_snap = rsp_co;
    id_snap = rsp_id;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check({name, ".hold"}, {rsp_valid, rsp_co, rsp_id, rsp_y}, {1'b1, co_snap, id_snap, y_snap});
      check({name, ".ready_in_done"}, req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    check({name, ".valid_drop"}, rsp_valid, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  vmask;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    int          stall;
    logic [31:0] exp_y;
    logic        exp_co;
    int          exp_id;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants[$];
    int          gcyc[$];
    int          cyc;
    int          eg;
    bit          silent;
    logic [31:0] a0, b0, a1, b1, ra, rb;
    logic        s0, s1, rs;
    logic [1:0]  mask;
    logic [33:0] r;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 0, 1'b0};
    vecs[1] = '{2'b10, 32'h0000_0005, 32'h0000_0007, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1, 1'b0};
    vecs[2] = '{2'b10, 32'h0000_0007, 32'h0000_0005, 1'b1, 5, 32'h0000_0002, 1'b1, 1, 1'b0};
    vecs[3] = '{2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 1'b0, 0, 1'b1};
    vecs[4] = '{2'b01, 32'h0000_0003, 32'h0000_0001, 1'b1, 0, 32'h0000_0002, 1'b1, 0, 1'b0};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 1'b1, 2, 32'h7FFF_FFFF, 1'b1, 1, 1'b1};
    vecs[6] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1, 0, 1'b0};
    vecs[7] = '{2'b10, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 0, 32'h2222_2221, 1'b0, 1, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset.valid", rsp_valid, 1'b0);
    check("reset.y", rsp_y, 32'h0);
    check("reset.co", rsp_co, 1'b0);
    check("reset.id", rsp_id, 1'b0);
`ifdef NX_ALU_SEQ_OVF_EN
    check("reset.ovf", rsp_ovf, 1'b0);
`endif
    check("reset.ready_idle", req_ready, 2'b00);

    // Round-robin with both requesters held valid and rsp_ready tied high
    @(negedge clk);
    req_valid = 2'b11;
    req_a     = {32'd7, 32'd3};
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    cyc       = 0;
    while (grants.size() < 4 && cyc < 200) begin
      #1;
      if (req_ready !== 2'b00) begin
        grants.push_back(req_ready === 2'b01 ? 0 : (req_ready === 2'b10 ? 1 : -1));
        gcyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    if (grants.size() < 4) note_fail("rr.grants");
    foreach (grants[i]) begin
      eg = exp_grant(2'b11, model_ptr);
      check($sformatf("rr.grant%0d", i), grants[i], eg);
      model_ptr = (eg + 1) % NREQ;
      if (i > 0) check($sformatf("rr.spacing%0d", i), gcyc[i] - gcyc[i-1], NCH + 2);
    end
    repeat (NCH + 4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rr.drained", rsp_valid, 1'b0);

    // Directed table
    foreach (vecs[i]) begin
      a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
      a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
      if (vecs[i].vmask[0]) begin a0 = vecs[i].a; b0 = vecs[i].b; s0 = vecs[i].sub; end
      else begin a1 = vecs[i].a; b1 = vecs[i].b; s1 = vecs[i].sub; end
      do_op($sformatf("vec%0d", i), vecs[i].vmask, a0, b0, s0, a1, b1, s1, vecs[i].stall,
            vecs[i].exp_y, vecs[i].exp_co, vecs[i].exp_id, vecs[i].exp_ovf);
    end

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      a1 = $urandom;
      b1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      s0 = 1'($urandom);
      s1 = 1'($urandom);
      eg = exp_grant(mask, model_ptr);
      ra = (eg == 0) ? a0 : a1;
      rb = (eg == 0) ? b0 : b1;
      rs = (eg == 0) ? s0 : s1;
      r  = ref_alu(ra, rb, rs);
      do_op($sformatf("rand%0d", i), mask, a0, b0, s0, a1, b1, s1,
            $urandom_range(0, 2), r[31:0], r[32], eg, r[33]);
    end

    // Reset during RUN at chunk k=3 aborts silently and clears rr
    @(negedge clk);
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h1111_1111};
    req_b     = {32'h0, 32'h2222_2222};
    req_sub   = 2'b00;
    @(posedge clk);
    #1;
    req_valid = '0;
    model_ptr = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_ptr = 0;
    check("abort.valid", rsp_valid, 1'b0);
    check("abort.y", rsp_y, 32'h0);
    check("abort.id", rsp_id, 1'b0);
    req_valid = 2'b11;
    #1;
    eg = exp_grant(2'b11, model_ptr);
    check("abort.rr_reset", req_ready, 2'(1 << eg));
    req_valid = '0;
    silent = 1'b1;
    repeat (NCH + 4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) silent = 1'b0;
    end
    check("abort.no_response", silent, 1'b1);

    // Recovery after abort
    r = ref_alu(32'd5, 32'd7, 1'b1);
    do_op("post_abort", 2'b10, 32'h0, 32'h0, 1'b0, 32'd5, 32'd7, 1'b1, 0,
          r[31:0], r[32], 1, r[33]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
